// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator. A horizontal pixel counter and a
//               vertical line counter walk the full raster. Every output is
//               registered from the *next* counter values, so the outputs
//               change on the same edge as x/y and never glitch.
//
// Ports       : clk          pixel clock (single clock domain)
//               rst          asynchronous, active-low reset
//               en           count enable; low freezes counters and outputs
//               hsync        horizontal sync (HS_POL while in the sync pulse)
//               vsync        vertical sync   (VS_POL while in the sync lines)
//               video_on     high only inside the visible area
//               x, y         current beam position (10 bits each)
//               line_start   high while x == 0
//               frame_start  high while x == 0 and y == 0
//               frame_cnt    16-bit frame counter; present only when the
//                            macro VGA_SYNC_FRAME_CNT_EN is defined
//
// Both totals (active + porches + sync) must not exceed 1024 so that the
// 10-bit x/y ports can hold every counter value.
//
// Revision    : 1.0  initial release
// ============================================================================
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Timing constants. Decode comparisons are done on 11 bits so that a
    // window ending exactly at 1024 is still representable.
    // ------------------------------------------------------------------------
    localparam int          c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
    localparam logic [10:0] c_v_last     = 11'(c_v_total - 1);
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Reset parks the beam on the last pixel of the last line, so the first
    // enabled edge lands on (0,0) and the first frame is complete.
    localparam logic [9:0]  c_h_rst      = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_rst      = 10'(c_v_total - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       video_on_q,    video_on_d;
    logic       line_start_q,  line_start_d;
    logic       frame_start_q, frame_start_d;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame_wrap;

    logic [10:0] w_h_next;
    logic [10:0] w_v_next;

    // ------------------------------------------------------------------------
    // Counter next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_wrap     = ({1'b0, h_cnt_q} == c_h_last);
        w_v_wrap     = ({1'b0, v_cnt_q} == c_v_last);
        w_frame_wrap = en && w_h_wrap && w_v_wrap;

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (w_h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = w_v_wrap ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the next counter values. When en is low the next
    // values equal the held ones, so the decode reproduces the held outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_next = {1'b0, h_cnt_d};
        w_v_next = {1'b0, v_cnt_d};

        hsync_d = ~HS_POL;
        if ((w_h_next >= c_hs_start) && (w_h_next < c_hs_end)) begin
            hsync_d = HS_POL;
        end

        // Vertical sync depends only on the line number, so it switches on
        // the same edge that moves x to 0.
        vsync_d = ~VS_POL;
        if ((w_v_next >= c_vs_start) && (w_v_next < c_vs_end)) begin
            vsync_d = VS_POL;
        end

        video_on_d    = (w_h_next < c_h_active) && (w_v_next < c_v_active);
        line_start_d  = (h_cnt_d == 10'd0);
        frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q       <= c_h_rst;
            v_cnt_q       <= c_v_rst;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    // ------------------------------------------------------------------------
    // Frame counter: counts edges that move the beam to (0,0); wraps freely.
    // ------------------------------------------------------------------------
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (w_frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    // Without the frame counter the frame-wrap strobe has no consumer.
    logic w_unused;
    assign w_unused = w_frame_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Scoreboard bench for vga_sync_gen. Two instances share
//               clk/rst/en: one with the 640x480 timing, one with a tiny
//               raster (and non-default sync polarities) so that whole
//               frames fit in a short run. The reference model tracks the
//               beam as a single linear position inside the frame and
//               derives every output from the region boundaries.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

    // Small raster: 15 clocks per line, 12 lines per frame.
    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VA = 5;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int N_S  = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int N_F  = 800 * 525;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   adv;
        bit   rstd;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic       hs_f, vs_f, von_f, ls_f, fs_f;
    logic [9:0] x_f, y_f;
    logic       hs_s, vs_s, von_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;
    logic [15:0] fc_f_dut, fc_s_dut;

    always #5 clk = ~clk;

    vga_sync_gen dut_f (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hsync      (hs_f),
        .vsync      (vs_f),
        .video_on   (von_f),
        .x          (x_f),
        .y          (y_f),
        .line_start (ls_f),
        .frame_start(fs_f)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (fc_f_dut)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL  (1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .video_on   (von_s),
        .x          (x_s),
        .y          (y_s),
        .line_start (ls_s),
        .frame_start(fs_s)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (fc_s_dut)
`endif
    );

`ifndef VGA_SYNC_FRAME_CNT_EN
    assign fc_f_dut = 16'd0;
    assign fc_s_dut = 16'd0;
`endif

    obs_t obs_f, obs_s;
    assign obs_f = {x_f, y_f, hs_f, vs_f, von_f, ls_f, fs_f, fc_f_dut};
    assign obs_s = {x_s, y_s, hs_s, vs_s, von_s, ls_s, fs_s, fc_s_dut};

    // ------------------------------------------------------------------------
    // Reference model: beam position is one integer in [0, frame length).
    // ------------------------------------------------------------------------
    int lin_f = N_F - 1;
    int lin_s = N_S - 1;
    int fc_f  = 0;
    int fc_s  = 0;

    item_t q_f[$];
    item_t q_s[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic obs_t model_obs(int lin, int fc, int ha, int hf, int hsw, int hb,
                                       int va, int vf, int vsw, int vb, logic hp, logic vp);
        obs_t o;
        int   ht, xx, yy;
        ht    = ha + hf + hsw + hb;
        xx    = lin % ht;
        yy    = lin / ht;
        o.x   = 10'(xx);
        o.y   = 10'(yy);
        o.hs  = (xx >= ha + hf && xx < ha + hf + hsw) ? hp : ~hp;
        o.vs  = (yy >= va + vf && yy < va + vf + vsw) ? vp : ~vp;
        o.von = (xx < ha) && (yy < va);
        o.ls  = (xx == 0);
        o.fs  = (lin == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        o.fc  = 16'(fc);
`else
        o.fc  = 16'd0;
`endif
        return o;
    endfunction

    function automatic obs_t exp_f();
        return model_obs(lin_f, fc_f, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic obs_t exp_s();
        return model_obs(lin_s, fc_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d hs=%0b vs=%0b von=%0b ls=%0b fs=%0b fc=%0d",
                         o.x, o.y, o.hs, o.vs, o.von, o.ls, o.fs, o.fc);
    endfunction

    task automatic check_obs(string name, obs_t act, obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got {%s} required {%s}", name, $time, fmt(act), fmt(exp));
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    endtask

    // Apply rst/en for the coming edge and queue the expected post-edge state.
    task automatic step_model(bit r, bit e);
        item_t it;
        if (!r) begin
            lin_f = N_F - 1; lin_s = N_S - 1; fc_f = 0; fc_s = 0;
        end else if (e) begin
            lin_f = (lin_f + 1) % N_F;
            lin_s = (lin_s + 1) % N_S;
            if (lin_f == 0) fc_f = (fc_f + 1) % 65536;
            if (lin_s == 0) fc_s = (fc_s + 1) % 65536;
        end
        it.adv  = r && e;
        it.rstd = !r;
        it.o    = exp_f();
        q_f.push_back(it);
        it.o    = exp_s();
        q_s.push_back(it);
    endtask

    task automatic cycle(bit r, bit e);
        @(negedge clk);
        rst = r;
        en  = e;
        step_model(r, e);
    endtask

    // Reset asserted between edges: outputs must change with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_obs("async_reset_full",
                  obs_f, model_obs(N_F - 1, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        check_obs("async_reset_small",
                  obs_s, model_obs(N_S - 1, 0, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1));
        step_model(1'b0, en);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pops one expectation per edge and compares; also checks line
    // and frame aggregates from the observed outputs.
    // ------------------------------------------------------------------------
    int  l_started = 0, l_von = 0, l_hs = 0, l_clk = 0;
    int  f_started = 0, f_von = 0, f_clk = 0;

    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q_f.size() > 0) begin
                it = q_f.pop_front();
                check_obs("full_beam", obs_f, it.o);
                if (it.rstd) l_started = 0;
                else if (it.adv) begin
                    if (ls_f) begin
                        if (l_started != 0) begin
                            check_int("line_video_on_clocks", l_von, 640);
                            check_int("line_hsync_clocks", l_hs, 96);
                            check_int("line_period", l_clk, 800);
                        end
                        l_started = 1; l_clk = 0; l_von = 0; l_hs = 0;
                    end
                    l_clk++;
                    if (von_f) l_von++;
                    if (hs_f == 1'b0) l_hs++;
                end
            end
            if (q_s.size() > 0) begin
                it = q_s.pop_front();
                check_obs("small_beam", obs_s, it.o);
                if (it.rstd) f_started = 0;
                else if (it.adv) begin
                    if (fs_s) begin
                        if (f_started != 0) begin
                            check_int("frame_video_on_clocks", f_von, S_HA * S_VA);
                            check_int("frame_period", f_clk, N_S);
                        end
                        f_started = 1; f_clk = 0; f_von = 0;
                    end
                    f_clk++;
                    if (von_s) f_von++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int tries;
        repeat (3) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);           // released, not yet enabled
        repeat (656) cycle(1'b1, 1'b1);         // full instance reaches x=655
        repeat (37) cycle(1'b1, 1'b0);          // freeze just before hsync
        repeat (1600) cycle(1'b1, 1'b1);
        repeat (1500) cycle(1'b1, ($urandom_range(0, 3) != 0));

        // Move to a point where the small raster is inside vsync and the
        // full raster is mid-line, then reset asynchronously.
        tries = 0;
        while (tries < 3000 &&
               !((lin_s >= 7 * 15) && (lin_s < 9 * 15) &&
                 (lin_f % 800 > 100) && (lin_f % 800 < 700))) begin
            cycle(1'b1, ($urandom_range(0, 3) != 0));
            tries++;
        end
        async_reset();
        repeat (2) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0);
        repeat (2500) cycle(1'b1, 1'b1);
        repeat (1000) cycle(1'b1, ($urandom_range(0, 4) != 0));

        @(posedge clk);
        #3;
        check_int("scoreboard_drained", q_f.size() + q_s.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
